fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction fetch queue between instruction memory (fetch stage) and decode; decouples fetch from decode stalls.
- Holds up to DEPTH {pc, instruction} pairs in FIFO order.
- Presents the head entry to decode; the head's low 24 bits go to decode as the immediate field for sign extension.
- Branch redirect flushes all queued entries.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- ADDR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_valid  input  1  fetch offers an instruction this cycle.
- imem_instr  input  32  fetched instruction word.
- imem_pc  input  32  PC of imem_instr.
- imem_ready  output  1  queue accepts a push this cycle.
- flush  input  1  branch redirect: discard all entries and any same-cycle push.
- id_valid  output  1  head entry valid for decode.
- id_instr  output  32  head instruction word.
- id_pc  output  32  head PC.
- id_imm  output  24  id_instr[23:0], immediate field to decode sign extension.
- id_ready  input  1  decode consumes the head this cycle (low = decode stall).
- count  output  ADDR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (async, rst=1): rd_ptr=0, wr_ptr=0, count=0, storage cleared to 0.
  - Outputs during and after reset: id_valid=0, id_instr=0, id_pc=0, id_imm=0, imem_ready=1.
- imem_ready = (count != DEPTH). Combinational from registered count only; no dependence on id_ready.
- id_valid = (count != 0). id_instr/id_pc = storage[rd_ptr]. id_imm = id_instr[23:0].
- push = imem_valid & imem_ready & ~flush. Writes {imem_pc, imem_instr} at wr_ptr; wr_ptr+1.
- pop = id_valid & id_ready & ~flush. rd_ptr+1.
- Pointers wrap modulo DEPTH (natural ADDR_W-bit overflow).
- count update:
  - push only: +1.
  - pop only: -1.
  - push & pop together: unchanged.
  - neither: unchanged.
- Latency: entry pushed in cycle N is visible on id_* in cycle N+1 when the queue was empty.
- Full (count=DEPTH): imem_ready=0; imem_valid ignored; a simultaneous pop still occurs, so count becomes DEPTH-1 and imem_ready=1 next cycle.
- Empty (count=0): id_valid=0; id_ready ignored; no pointer movement.
- Flush has priority over push and pop.
  - Next cycle: count=0, rd_ptr=wr_ptr=0, id_valid=0.
  - Storage contents are not cleared.
- Flush while empty: no visible change.
- Reset asserted mid-operation: immediate return to reset state regardless of pending push/pop/flush.
- id_* outputs hold stable while id_valid=1 and id_ready=0.
- Fetch holds imem_* stable while imem_valid=1 and imem_ready=0; the queue does not check this.

Optional Feature:
- Macro FQ_BYPASS_EN.
- Defined:
  - When count=0 and imem_valid=1 and flush=0, id_valid=1 and id_instr/id_pc/id_imm are driven combinationally from imem_*.
  - If id_ready=1 that cycle, the entry is consumed without being written; count stays 0.
  - If id_ready=0, the entry is pushed normally.
  - Zero-cycle latency when empty.
- Undefined: no bypass; minimum latency of one cycle as described above.

Test Plan:
- Reset then idle: rst pulse, no stimulus -> id_valid=0, count=0, imem_ready=1, id_instr=0x00000000.
- Single entry: push instr=0xEA00000F, pc=0x00000010, id_ready=1 -> next cycle id_valid=1, id_imm=0x00000F, id_pc=0x10; following cycle count=0.
- Fill to full: id_ready=0, push 5 consecutive instrs -> count=4, imem_ready=0 after 4th, 5th not stored. Then id_ready=1 -> heads emerge in push order.
- Simultaneous push/pop at count=2 -> count stays 2; order preserved across pointer wrap (push 10 entries total).
- Flush: count=3, assert flush with imem_valid=1 and id_ready=1 -> next cycle count=0, id_valid=0; the flush-cycle push is absent from later outputs.
- Async reset mid-stream: rst asserted between clock edges with count=3 -> outputs go to reset values before the next clk edge. With FQ_BYPASS_EN, empty-queue push with id_ready=1 -> id_valid=1 in the same cycle and count remains 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO of {pc, instr} between fetch and decode.
// Optional same-cycle bypass of an empty queue is enabled by defining FQ_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_valid,
  input  logic [31:0]       imem_instr,
  input  logic [31:0]       imem_pc,
  output logic              imem_ready,
  input  logic              flush,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc,
  output logic [23:0]       id_imm,
  input  logic              id_ready,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [31:0]       instr_mem [DEPTH];
  logic [31:0]       pc_mem    [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              push;
  logic              pop;
  logic              bypass;

  // Head presentation, handshake qualification and optional empty-queue bypass
  always_comb begin
    imem_ready = (count != CNT_FULL);
    id_valid   = (count != CNT_ZERO);
    id_instr   = instr_mem[rd_ptr];
    id_pc      = pc_mem[rd_ptr];
    bypass     = 1'b0;
`ifdef FQ_BYPASS_EN
    if ((count == CNT_ZERO) && imem_valid && !flush) begin
      bypass   = 1'b1;
      id_valid = 1'b1;
      id_instr = imem_instr;
      id_pc    = imem_pc;
    end else begin
      bypass   = 1'b0;
    end
`endif
    // A bypassed entry taken by decode is never written into storage
    pop  = (count != CNT_ZERO) & id_ready & ~flush;
    push = imem_valid & imem_ready & ~flush & ~(bypass & id_ready);
  end

  assign id_imm = id_instr[23:0];

  // Entry storage: cleared on reset, untouched by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= 32'h0000_0000;
        pc_mem[i]    <= 32'h0000_0000;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= imem_instr;
      pc_mem[wr_ptr]    <= imem_pc;
    end else begin
      instr_mem[wr_ptr] <= instr_mem[wr_ptr];
      pc_mem[wr_ptr]    <= pc_mem[wr_ptr];
    end
  end

  // Pointers and occupancy; flush outranks push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= PTR_ZERO;
      wr_ptr <= PTR_ZERO;
      count  <= CNT_ZERO;
    end else if (flush) begin
      rd_ptr <= PTR_ZERO;
      wr_ptr <= PTR_ZERO;
      count  <= CNT_ZERO;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
